// File: rtl/rotate_shift_ctrl.sv
// rotate_shift_ctrl: two-stage valid/ready pipeline that rotates a data word
// left by a requested or accumulated amount.
// S1 registers the word and its effective shift. S2 registers the rotated
// result and drives the outputs. The rotator between the stages is the
// N_rotate_left_shifter below.

// N_rotate_left_shifter: combinational barrel rotator, one mux layer per
// shift-amount bit. Layer i rotates left by 2**i when shift[i] is set.
module N_rotate_left_shifter #(
    parameter int DATA_WIDTH  = 8,
    parameter int SHIFT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic [DATA_WIDTH-1:0]  data,
    input  logic [SHIFT_WIDTH-1:0] shift,
    output logic [DATA_WIDTH-1:0]  rotated
);

    logic [DATA_WIDTH-1:0] layer [0:SHIFT_WIDTH];

    assign layer[0] = data;

    genvar i;
    generate
        for (i = 0; i < SHIFT_WIDTH; i++) begin : g_layer
            localparam int AMT = 1 << i;
            assign layer[i+1] = shift[i]
                ? {layer[i][DATA_WIDTH-1-AMT:0], layer[i][DATA_WIDTH-1:DATA_WIDTH-AMT]}
                : layer[i];
        end
    endgenerate

    assign rotated = layer[SHIFT_WIDTH];

endmodule

module rotate_shift_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int SHIFT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [DATA_WIDTH-1:0]  IDATA,
    input  logic [SHIFT_WIDTH-1:0] N_SHIFT,
    input  logic                   ACC_EN,
    input  logic                   CLR_ACC,
    input  logic                   IVALID,
    output logic                   IREADY,
    output logic [DATA_WIDTH-1:0]  ODATA,
    output logic [SHIFT_WIDTH-1:0] OSHIFT,
    output logic                   OVALID,
    input  logic                   OREADY
);

    logic [DATA_WIDTH-1:0]  s1_data;
    logic [SHIFT_WIDTH-1:0] s1_shift;
    logic                   s1_valid;

    logic [DATA_WIDTH-1:0]  s2_data;
    logic [SHIFT_WIDTH-1:0] s2_shift;
    logic                   s2_valid;

    logic [SHIFT_WIDTH-1:0] acc;
    logic [SHIFT_WIDTH-1:0] acc_base;
    logic [SHIFT_WIDTH-1:0] eff_shift;
    logic [DATA_WIDTH-1:0]  rot_data;

    logic                   s2_advance;
    logic                   in_xfer;

    // S2 can take a new word when it is empty or its word leaves this cycle.
    assign s2_advance = !s2_valid || OREADY;
    // S1 can take a word when empty or when it drains into S2. Depends only
    // on registered state and OREADY, never on IVALID.
    assign IREADY     = !s1_valid || s2_advance;
    assign in_xfer    = IVALID && IREADY;

    // Effective shift. A clear in the same cycle zeroes the base before the
    // add. The sum wraps naturally because DATA_WIDTH is a power of two.
    always_comb begin
        acc_base  = CLR_ACC ? '0 : acc;
        eff_shift = ACC_EN ? (acc_base + N_SHIFT) : N_SHIFT;
    end

    // Accumulator. An accumulating transfer wins. Otherwise a clear applies
    // even when no word transfers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            acc <= '0;
        end else if (in_xfer && ACC_EN) begin
            acc <= eff_shift;
        end else if (CLR_ACC) begin
            acc <= '0;
        end
    end

    // Stage 1: capture the incoming word and its effective shift.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_shift <= '0;
        end else if (IREADY) begin
            s1_valid <= IVALID;
            if (IVALID) begin
                s1_data  <= IDATA;
                s1_shift <= eff_shift;
            end
        end
    end

    N_rotate_left_shifter #(
        .DATA_WIDTH  (DATA_WIDTH),
        .SHIFT_WIDTH (SHIFT_WIDTH)
    ) u_rotator (
        .data    (s1_data),
        .shift   (s1_shift),
        .rotated (rot_data)
    );

    // Stage 2: register the rotated word. It holds while downstream stalls.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_shift <= '0;
        end else if (s2_advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data  <= rot_data;
                s2_shift <= s1_shift;
            end
        end
    end

    assign ODATA  = s2_data;
    assign OSHIFT = s2_shift;
    assign OVALID = s2_valid;

endmodule

// File: tb/tb_rotate_shift_ctrl.sv
// Directed bench for rotate_shift_ctrl at DATA_WIDTH=8. Expected values
// are hand-computed rotations.
module tb_rotate_shift_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] IDATA = '0;
    logic [2:0] N_SHIFT = '0;
    logic       ACC_EN = 1'b0;
    logic       CLR_ACC = 1'b0;
    logic       IVALID = 1'b0;
    logic       IREADY;
    logic [7:0] ODATA;
    logic [2:0] OSHIFT;
    logic       OVALID;
    logic       OREADY = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    rotate_shift_ctrl #(.DATA_WIDTH(8)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .IDATA   (IDATA),
        .N_SHIFT (N_SHIFT),
        .ACC_EN  (ACC_EN),
        .CLR_ACC (CLR_ACC),
        .IVALID  (IVALID),
        .IREADY  (IREADY),
        .ODATA   (ODATA),
        .OSHIFT  (OSHIFT),
        .OVALID  (OVALID),
        .OREADY  (OREADY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 ns after it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] d, input logic [2:0] s);
        chk({tag, ".ovalid"}, {31'b0, OVALID}, 32'd1);
        chk({tag, ".odata"},  {24'b0, ODATA},  {24'b0, d});
        chk({tag, ".oshift"}, {29'b0, OSHIFT}, {29'b0, s});
    endtask

    initial begin
        // Reset values, applied asynchronously before any clock edge.
        #1 RST = 1'b1;
        #2;
        chk("rst.ovalid", {31'b0, OVALID}, 32'd0);
        chk("rst.odata",  {24'b0, ODATA},  32'd0);
        chk("rst.oshift", {29'b0, OSHIFT}, 32'd0);
        chk("rst.iready", {31'b0, IREADY}, 32'd1);
        tick();
        tick();
        RST = 1'b0;
        tick();

        // B4 rotated left by 3 = A5. The result appears one edge after the
        // transfer edge.
        IDATA = 8'hB4; N_SHIFT = 3'd3; ACC_EN = 1'b0; IVALID = 1'b1; OREADY = 1'b1;
        tick();
        IVALID = 1'b0;
        chk("lat.early", {31'b0, OVALID}, 32'd0);
        tick();
        chk_out("b4", 8'hA5, 3'd3);
        tick();
        chk("b4.drain", {31'b0, OVALID}, 32'd0);

        // Accumulate 3 per word: shifts 3, 6, then 9 mod 8 = 1.
        IDATA = 8'h01; N_SHIFT = 3'd3; ACC_EN = 1'b1; IVALID = 1'b1;
        tick();
        tick();
        chk_out("acc0", 8'h08, 3'd3);
        tick();
        IVALID = 1'b0;
        chk_out("acc1", 8'h40, 3'd6);
        tick();
        chk_out("acc2", 8'h02, 3'd1);
        tick();
        chk("acc.drain", {31'b0, OVALID}, 32'd0);

        // Downstream stall: two words accepted, then back-pressure.
        // The accumulator holds 1 from the previous sequence.
        ACC_EN = 1'b0; OREADY = 1'b0; N_SHIFT = 3'd1;
        IDATA = 8'h11; IVALID = 1'b1;
        chk("bp.iready0", {31'b0, IREADY}, 32'd1);
        tick();
        IDATA = 8'h22;
        chk("bp.iready1", {31'b0, IREADY}, 32'd1);
        tick();
        IDATA = 8'h33;
        chk("bp.iready2", {31'b0, IREADY}, 32'd0);
        chk_out("bp.hold0", 8'h22, 3'd1);
        tick();
        chk("bp.iready3", {31'b0, IREADY}, 32'd0);
        chk_out("bp.hold1", 8'h22, 3'd1);
        tick();
        chk_out("bp.hold2", 8'h22, 3'd1);
        OREADY = 1'b1;
        #1;
        chk("bp.iready4", {31'b0, IREADY}, 32'd1);
        tick();
        IVALID = 1'b0;
        chk_out("bp.o44", 8'h44, 3'd1);
        tick();
        chk_out("bp.o66", 8'h66, 3'd1);
        tick();
        chk("bp.drain", {31'b0, OVALID}, 32'd0);

        // Clear with accumulate. The first word sets acc to 5. The second
        // word clears and adds 2, giving shift 2. The third word adds 0,
        // which shows acc is now 2.
        ACC_EN = 1'b1; CLR_ACC = 1'b1; N_SHIFT = 3'd5; IDATA = 8'h01; IVALID = 1'b1;
        tick();
        N_SHIFT = 3'd2; IDATA = 8'h81;
        tick();
        chk_out("clr.w5", 8'h20, 3'd5);
        CLR_ACC = 1'b0; N_SHIFT = 3'd0; IDATA = 8'h0F;
        tick();
        IVALID = 1'b0;
        chk_out("clr.w2", 8'h06, 3'd2);
        tick();
        chk_out("clr.acc2", 8'h3C, 3'd2);

        // A clear with no transfer still zeroes acc: the next shift is 3, not 5.
        CLR_ACC = 1'b1;
        tick();
        CLR_ACC = 1'b0; IDATA = 8'h01; N_SHIFT = 3'd3; IVALID = 1'b1;
        tick();
        IVALID = 1'b0;
        tick();
        chk_out("clr.idle", 8'h08, 3'd3);
        tick();

        // Fill both stages, then reset asynchronously between edges.
        OREADY = 1'b0; N_SHIFT = 3'd2; IDATA = 8'hAA; IVALID = 1'b1;
        tick();
        IDATA = 8'h55;
        tick();
        IVALID = 1'b0;
        chk("mid.full", {31'b0, OVALID}, 32'd1);
        #2 RST = 1'b1;
        #1;
        chk("mid.ovalid", {31'b0, OVALID}, 32'd0);
        chk("mid.odata",  {24'b0, ODATA},  32'd0);
        chk("mid.oshift", {29'b0, OSHIFT}, 32'd0);
        chk("mid.iready", {31'b0, IREADY}, 32'd1);
        tick();
        RST = 1'b0;
        OREADY = 1'b1; IDATA = 8'h01; N_SHIFT = 3'd1; ACC_EN = 1'b1; IVALID = 1'b1;
        tick();
        IVALID = 1'b0;
        chk("post.lat", {31'b0, OVALID}, 32'd0);
        tick();
        chk_out("post", 8'h02, 3'd1);
        tick();
        chk("post.drain", {31'b0, OVALID}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
